encoder_8_to_3_stream: RTL and testbench
========================================

# encoder_8_to_3_stream

Sequential 8-to-3 encoder: the inverse of the 3-to-8 one-hot decoder path. It captures an 8-bit line vector through a valid/ready handshake, then streams the 3-bit index of every set line, one index per beat, in a fixed priority order. It sits between decoded line/request sources and index-consuming logic, and also serves as the round-trip checker for the decoder.

## Interface
Parameters: none. Width is fixed at 8 lines and a 3-bit index.

Ports:
- i_clk  in  1  clock; all logic is on the rising edge
- i_rst  in  1  synchronous reset, active-high
- i_en  in  1  enable; gates acceptance of new vectors only
- i_valid  in  1  input vector valid
- o_ready  out  1  input ready; equals (state==IDLE) && i_en
- i_y  in  8  line vector to encode
- o_valid  out  1  output index valid (registered)
- i_ready  in  1  downstream accepts index
- o_a  out  3  encoded index (registered)
- o_last  out  1  current beat is the final beat of this vector
- o_zero  out  1  captured vector was all-zero
- o_count  out  4  set lines remaining, including the current beat (0..8)

## Operation
- States are IDLE and DRAIN. Reset forces IDLE.
- Register reset values: o_valid=0, o_a=0, o_last=0, o_zero=0, o_count=0, internal vector=0.
- IDLE:
  - When i_valid && o_ready, latch i_y and enter DRAIN.
  - o_count = popcount(i_y). o_a is the first index in priority order.
  - o_last=1 if popcount ≤ 1.
- Zero vector: produces exactly one beat with o_a=0, o_zero=1, o_last=1, o_count=0.
- DRAIN:
  - o_valid=1.
  - On o_valid && i_ready:
    - Clear the bit at o_a and decrement o_count.
    - Load the next index and o_last.
    - If o_last was 1, return to IDLE, clear o_valid, o_last and o_zero, and clear o_count to 0.
- Backpressure: while o_valid && !i_ready, o_a, o_last, o_count and o_zero hold stable and o_valid stays high.
- i_en deasserted in DRAIN does not stall or abort the drain. In IDLE it holds o_ready=0, and i_y is ignored.
- Reset mid-drain: the vector is discarded and all outputs return to reset values at that edge.
- Simultaneous i_rst and i_valid: reset wins; nothing is captured.

## Timing
- Capture at edge N puts o_valid=1 with the first index in cycle N+1. Capture-to-first-index latency is 1 cycle.
- With i_ready held high, one index per cycle. A vector with k set lines drains in k cycles.
- After the final handshake at edge M, the block is in IDLE at M+1, and o_ready=i_en in that cycle. The earliest next capture is edge M+1, so there is one bubble cycle between vectors.
- o_ready is combinational from state and i_en. All other outputs are registered.

## Configuration
- ENC_MSB_FIRST_EN:
  - Defined: highest set index is emitted first (7 down to 0).
  - Undefined (default): lowest set index first (0 up to 7).
- Port list and timing are identical in both builds.

## Test plan
- Reset: hold i_rst=1 for 2 cycles with i_valid=1, i_y=8'hFF.
  - Required: o_valid=0, o_a=0, o_last=0, o_zero=0, o_count=0, and no capture.
  - Then i_rst=0, i_en=1 gives o_ready=1.
- One-hot sweep: i_y=8'b1<<k for k=0..7, i_ready=1.
  - Required: each vector gives exactly one beat one cycle after capture, with o_a=k, o_last=1, o_count=1.
- Multi-bit vector: i_y=8'b1010_0110, i_ready=1.
  - Default build: o_a=1,2,5,7 on consecutive cycles, o_count=4,3,2,1, o_last only on 7.
  - With ENC_MSB_FIRST_EN: o_a=7,5,2,1.
- Backpressure: i_y=8'hFF with i_ready low for 3 cycles after the 2nd beat.
  - Required: o_valid, o_a and o_count hold stable during the stall.
  - Required: all 8 indices are delivered, and none is duplicated.
- Zero and enable:
  - i_y=8'h00 must give one beat with o_zero=1, o_a=0, o_last=1, o_count=0.
  - With i_en=0 and i_valid=1, o_ready=0 and there is no capture.
  - Dropping i_en mid-drain must not interrupt the drain.
- Reset mid-drain: i_y=8'hFF, assert i_rst after the 3rd beat.
  - Required: o_valid=0 and o_count=0 in the next cycle.
  - Required: a following i_y=8'h10 drains cleanly as a single beat with o_a=4.

Source files
------------

// File: rtl/encoder_8_to_3_stream_if.sv
// Handshake bundle for encoder_8_to_3_stream: vector capture side (i_valid/o_ready/i_y)
// and index stream side (o_valid/i_ready/o_a plus beat status).
interface encoder_8_to_3_stream_if;
    logic       i_en;
    logic       i_valid;
    logic       o_ready;
    logic [7:0] i_y;
    logic       o_valid;
    logic       i_ready;
    logic [2:0] o_a;
    logic       o_last;
    logic       o_zero;
    logic [3:0] o_count;

    modport slave (
        input  i_en,
        input  i_valid,
        output o_ready,
        input  i_y,
        output o_valid,
        input  i_ready,
        output o_a,
        output o_last,
        output o_zero,
        output o_count
    );

    modport master (
        output i_en,
        output i_valid,
        input  o_ready,
        output i_y,
        input  o_valid,
        output i_ready,
        input  o_a,
        input  o_last,
        input  o_zero,
        input  o_count
    );
endinterface

// File: rtl/encoder_8_to_3_stream.sv
// Captures an 8-bit line vector and streams the index of every set line, one per beat.
// ENC_MSB_FIRST_EN: when defined, highest index first; otherwise lowest index first.
//
// state | meaning
// IDLE  | waiting for a vector; o_ready = i_en
// DRAIN | o_valid high, emitting one index per accepted beat
module encoder_8_to_3_stream (
    input  logic                        i_clk,
    input  logic                        i_rst,
    encoder_8_to_3_stream_if.slave      bus
);
    typedef enum logic {IDLE, DRAIN} state_t;

    state_t     state;
    state_t     state_nxt;
    logic [7:0] vec;
    logic [7:0] vec_nxt;
    logic [7:0] vec_rem;
    logic       valid_nxt;
    logic [2:0] a_nxt;
    logic       last_nxt;
    logic       zero_nxt;
    logic [3:0] count_nxt;

    function automatic logic [3:0] popcount(input logic [7:0] v);
        logic [3:0] c;
        c = 4'd0;
        for (int i = 0; i < 8; i++) begin
            c = c + {3'd0, v[i]};
        end
        return c;
    endfunction

    // Scan toward the favoured end so the last hit is the winner.
    function automatic logic [2:0] first_idx(input logic [7:0] v);
        logic [2:0] idx;
        idx = 3'd0;
`ifdef ENC_MSB_FIRST_EN
        for (int i = 0; i < 8; i++) begin
            if (v[i]) idx = 3'(i);
        end
`else
        for (int i = 7; i >= 0; i--) begin
            if (v[i]) idx = 3'(i);
        end
`endif
        return idx;
    endfunction

    assign bus.o_ready = (state == IDLE) && bus.i_en;
    assign vec_rem     = vec & ~(8'd1 << bus.o_a);

    always_comb begin
        state_nxt = state;
        vec_nxt   = vec;
        valid_nxt = bus.o_valid;
        a_nxt     = bus.o_a;
        last_nxt  = bus.o_last;
        zero_nxt  = bus.o_zero;
        count_nxt = bus.o_count;
        case (state)
            IDLE: begin
                if (bus.i_valid && bus.o_ready) begin
                    state_nxt = DRAIN;
                    vec_nxt   = bus.i_y;
                    valid_nxt = 1'b1;
                    a_nxt     = first_idx(bus.i_y);
                    count_nxt = popcount(bus.i_y);
                    last_nxt  = popcount(bus.i_y) <= 4'd1;
                    zero_nxt  = bus.i_y == 8'd0;
                end
            end
            DRAIN: begin
                if (bus.o_valid && bus.i_ready) begin
                    if (bus.o_last) begin
                        state_nxt = IDLE;
                        vec_nxt   = 8'd0;
                        valid_nxt = 1'b0;
                        a_nxt     = 3'd0;
                        last_nxt  = 1'b0;
                        zero_nxt  = 1'b0;
                        count_nxt = 4'd0;
                    end else begin
                        vec_nxt   = vec_rem;
                        a_nxt     = first_idx(vec_rem);
                        count_nxt = bus.o_count - 4'd1;
                        last_nxt  = popcount(vec_rem) <= 4'd1;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state       <= IDLE;
            vec         <= 8'd0;
            bus.o_valid <= 1'b0;
            bus.o_a     <= 3'd0;
            bus.o_last  <= 1'b0;
            bus.o_zero  <= 1'b0;
            bus.o_count <= 4'd0;
        end else begin
            state       <= state_nxt;
            vec         <= vec_nxt;
            bus.o_valid <= valid_nxt;
            bus.o_a     <= a_nxt;
            bus.o_last  <= last_nxt;
            bus.o_zero  <= zero_nxt;
            bus.o_count <= count_nxt;
        end
    end
endmodule

// File: tb/tb_encoder_8_to_3_stream.sv
// Directed and randomized bench for encoder_8_to_3_stream; expected beats come from a
// queue of set-line indices built arithmetically from each captured vector.
module tb_encoder_8_to_3_stream;
    logic i_clk;
    logic i_rst;
    int   checks;
    int   failures;

    encoder_8_to_3_stream_if bus ();

    encoder_8_to_3_stream dut (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .bus   (bus.slave)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_valid"}, 32'(bus.o_valid), 32'd0);
        chk({tag, "_a"},     32'(bus.o_a),     32'd0);
        chk({tag, "_last"},  32'(bus.o_last),  32'd0);
        chk({tag, "_zero"},  32'(bus.o_zero),  32'd0);
        chk({tag, "_count"}, 32'(bus.o_count), 32'd0);
    endtask

    // Called at a negedge with the DUT idle and i_en=1. stall_at/en_drop_at/abort_at
    // count accepted beats; -1 disables that event.
    task automatic send(input logic [7:0] v, input int stall_at, input int stall_len,
                        input int en_drop_at, input int abort_at, input bit rand_rdy);
        int  q[$];
        bit  zero;
        int  beats;
        int  stalled;
        int  cyc;
        bit  rdy;
        zero = (v == 8'd0);
        for (int k = 0; k < 8; k++) begin
            if (((v >> k) & 8'd1) != 8'd0) begin
`ifdef ENC_MSB_FIRST_EN
                q.push_front(k);
`else
                q.push_back(k);
`endif
            end
        end
        if (zero) q.push_back(0);

        bus.i_y     = v;
        bus.i_valid = 1'b1;
        bus.i_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
        #1;
        chk("cap_ready", 32'(bus.o_ready), 32'd1);
        @(negedge i_clk);
        bus.i_valid = 1'b0;
        bus.i_y     = 8'($urandom);

        beats   = 0;
        stalled = 0;
        cyc     = 0;
        while (q.size() > 0 && cyc < 64) begin
            chk("beat_valid", 32'(bus.o_valid), 32'd1);
            chk("beat_a",     32'(bus.o_a),     32'(q[0]));
            chk("beat_count", 32'(bus.o_count), zero ? 32'd0 : 32'(q.size()));
            chk("beat_last",  32'(bus.o_last),  32'(q.size() == 1));
            chk("beat_zero",  32'(bus.o_zero),  32'(zero));
            if (beats == abort_at) begin
                bus.i_ready = 1'b0;
                i_rst       = 1'b1;
                @(negedge i_clk);
                chk_idle_outputs("abort");
                i_rst = 1'b0;
                return;
            end
            if (beats == en_drop_at) bus.i_en = 1'b0;
            if (beats == stall_at && stalled < stall_len) begin
                rdy = 1'b0;
                stalled++;
            end else if (rand_rdy) begin
                rdy = 1'($urandom_range(0, 1));
            end else begin
                rdy = 1'b1;
            end
            bus.i_ready = rdy;
            @(negedge i_clk);
            if (rdy) begin
                void'(q.pop_front());
                beats++;
            end
            cyc++;
        end
        chk("drain_left", 32'(q.size()), 32'd0);
        chk_idle_outputs("post");
        chk("post_ready", 32'(bus.o_ready), 32'(bus.i_en));
        bus.i_en    = 1'b1;
        bus.i_ready = 1'b0;
    endtask

    initial begin
        checks      = 0;
        failures    = 0;
        i_rst       = 1'b1;
        bus.i_en    = 1'b1;
        bus.i_valid = 1'b1;
        bus.i_y     = 8'hFF;
        bus.i_ready = 1'b1;

        // Reset held two cycles with a valid vector present.
        @(negedge i_clk);
        chk_idle_outputs("rst1");
        @(negedge i_clk);
        chk_idle_outputs("rst2");
        i_rst       = 1'b0;
        bus.i_valid = 1'b0;
        #1;
        chk("rst_ready", 32'(bus.o_ready), 32'd1);
        @(negedge i_clk);
        chk_idle_outputs("rst_nocap");

        for (int k = 0; k < 8; k++) begin
            send(8'd1 << k, -1, 0, -1, -1, 1'b0);
        end

        send(8'b1010_0110, -1, 0, -1, -1, 1'b0);

        send(8'hFF, 2, 3, -1, -1, 1'b0);

        send(8'h00, -1, 0, -1, -1, 1'b0);

        // Enable low blocks capture.
        bus.i_en    = 1'b0;
        bus.i_valid = 1'b1;
        bus.i_y     = 8'hAA;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("en0_ready", 32'(bus.o_ready), 32'd0);
            @(negedge i_clk);
            chk("en0_valid", 32'(bus.o_valid), 32'd0);
        end
        bus.i_valid = 1'b0;
        bus.i_en    = 1'b1;
        @(negedge i_clk);

        send(8'b0111_1001, -1, 0, 1, -1, 1'b0);

        send(8'hFF, -1, 0, -1, 3, 1'b0);
        send(8'h10, -1, 0, -1, -1, 1'b0);

        for (int r = 0; r < 20; r++) begin
            send(8'($urandom), -1, 0, int'($urandom_range(0, 9)) - 2, -1, 1'b1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
